// File: rtl/bit_debouncer.sv
// bit_debouncer: synchronises a raw level, qualifies each change for
// STABLE_CYCLES enabled clocks, and presents a clean level plus
// one-cycle rise/fall strobes. Every output is registered.
module bit_debouncer #(
  parameter int SYNC_STAGES   = 2,
  parameter int CNT_W         = 8,
  parameter int STABLE_CYCLES = 16
) (
  input  logic CLK,
  input  logic CLR,
  input  logic D,
  input  logic EN,
  output logic Q,
  output logic RISE,
  output logic FALL,
  output logic BUSY
);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    CHK_HI  = 2'd1,
    IDLE_HI = 2'd2,
    CHK_LO  = 2'd3
  } state_t;

  // Final count value before a commit; STABLE_CYCLES = 2**CNT_W still fits.
  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_next;

  logic                   w_q_next;
  logic                   w_rise_next;
  logic                   w_fall_next;
  logic                   w_busy_next;

  // First synchroniser stage samples the raw input every clock.
  always_ff @(posedge CLK) begin
    if (CLR) r_sync[0] <= 1'b0;
    else     r_sync[0] <= D;
  end

  // Remaining synchroniser stages shift unconditionally (never gated by EN).
  for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
    always_ff @(posedge CLK) begin
      if (CLR) r_sync[gi] <= 1'b0;
      else     r_sync[gi] <= r_sync[gi-1];
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // State, counter and registered outputs; clear overrides any pending commit.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_state <= IDLE_LO;
      r_cnt   <= '0;
      Q       <= 1'b0;
      RISE    <= 1'b0;
      FALL    <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      Q       <= w_q_next;
      RISE    <= w_rise_next;
      FALL    <= w_fall_next;
      BUSY    <= w_busy_next;
    end
  end

  // Next-state and counter: entering a check is unconditional, mismatches
  // abort regardless of EN, and only EN-qualified matching cycles count.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      IDLE_LO: begin
        if (w_s) begin
          w_state_next = CHK_HI;
          w_cnt_next   = '0;
        end
      end
      CHK_HI: begin
        if (!w_s) begin
          w_state_next = IDLE_LO;
          w_cnt_next   = '0;
        end else if (EN) begin
          if (r_cnt == LP_CNT_LAST) begin
            w_state_next = IDLE_HI;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      IDLE_HI: begin
        if (!w_s) begin
          w_state_next = CHK_LO;
          w_cnt_next   = '0;
        end
      end
      CHK_LO: begin
        if (w_s) begin
          w_state_next = IDLE_HI;
          w_cnt_next   = '0;
        end else if (EN) begin
          if (r_cnt == LP_CNT_LAST) begin
            w_state_next = IDLE_LO;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = IDLE_LO;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Output values for the coming edge, derived from the state transition so
  // strobes fire only on a commit and coincide with the Q change.
  always_comb begin
    w_q_next    = (w_state_next == IDLE_HI) || (w_state_next == CHK_LO);
    w_busy_next = (w_state_next == CHK_HI)  || (w_state_next == CHK_LO);
    w_rise_next = (r_state == CHK_HI) && (w_state_next == IDLE_HI);
    w_fall_next = (r_state == CHK_LO) && (w_state_next == IDLE_LO);
  end

endmodule

// File: tb/tb_bit_debouncer.sv
// tb_bit_debouncer: directed scenarios for bit_debouncer with hand-derived
// expected outputs. A second instance checks the short-window corner.
`timescale 1ns/1ps
module tb_bit_debouncer;

  logic CLK = 1'b0;
  logic CLR = 1'b1;
  logic D   = 1'b0;
  logic EN  = 1'b1;
  logic Q, RISE, FALL, BUSY;
  logic Q2, RISE2, FALL2, BUSY2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  bit_debouncer #(.SYNC_STAGES(2), .CNT_W(8), .STABLE_CYCLES(16)) dut (
    .CLK(CLK), .CLR(CLR), .D(D), .EN(EN),
    .Q(Q), .RISE(RISE), .FALL(FALL), .BUSY(BUSY)
  );

  // Short window: 3 sync stages, 1 qualifying cycle -> commit on edge 5.
  bit_debouncer #(.SYNC_STAGES(3), .CNT_W(4), .STABLE_CYCLES(1)) dut2 (
    .CLK(CLK), .CLR(CLR), .D(D), .EN(EN),
    .Q(Q2), .RISE(RISE2), .FALL(FALL2), .BUSY(BUSY2)
  );

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] got;
    CLR = 1'b1; D = 1'b1; EN = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      got = {Q, RISE, FALL, BUSY};
      n_checks++;
      if (got !== 4'b0000) begin
        n_errors++;
        $display("FAIL reset cyc=%0d {Q,RISE,FALL,BUSY} got=%b exp=0000", k, got);
      end
    end
  endtask

  // D high for 5 sampled edges then low: busy after edges 3..7, no commit.
  task automatic test_glitch();
    logic [3:0] got, exp;
    CLR = 1'b0; D = 1'b0; EN = 1'b1;
    for (int k = 1; k <= 4; k++) tick();
    for (int k = 1; k <= 25; k++) begin
      D = (k <= 5);
      tick();
      got = {Q, RISE, FALL, BUSY};
      exp = {1'b0, 1'b0, 1'b0, (k >= 3 && k <= 7)};
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL glitch edge=%0d {Q,RISE,FALL,BUSY} got=%b exp=%b", k, got, exp);
      end
    end
  endtask

  task automatic test_rise();
    logic [3:0] got, exp;
    logic [3:0] got2, exp2;
    D = 1'b1; EN = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      got = {Q, RISE, FALL, BUSY};
      exp = {(k >= 19), (k == 19), 1'b0, (k >= 3 && k <= 18)};
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL rise edge=%0d {Q,RISE,FALL,BUSY} got=%b exp=%b", k, got, exp);
      end
      got2 = {Q2, RISE2, FALL2, BUSY2};
      exp2 = {(k >= 5), (k == 5), 1'b0, (k == 4)};
      n_checks++;
      if (got2 !== exp2) begin
        n_errors++;
        $display("FAIL rise_short edge=%0d {Q,RISE,FALL,BUSY} got=%b exp=%b", k, got2, exp2);
      end
    end
  endtask

  task automatic test_fall();
    logic [3:0] got, exp;
    D = 1'b0; EN = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      got = {Q, RISE, FALL, BUSY};
      exp = {(k < 19), 1'b0, (k == 19), (k >= 3 && k <= 18)};
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL fall edge=%0d {Q,RISE,FALL,BUSY} got=%b exp=%b", k, got, exp);
      end
    end
  endtask

  // EN high only on even edges; check entered at edge 3, 16th enabled edge is 34.
  task automatic test_en_alternate();
    logic [3:0] got, exp;
    D = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      EN = (k % 2 == 0);
      tick();
      got = {Q, RISE, FALL, BUSY};
      exp = {(k >= 34), (k == 34), 1'b0, (k >= 3 && k <= 33)};
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL en_alt edge=%0d {Q,RISE,FALL,BUSY} got=%b exp=%b", k, got, exp);
      end
    end
    EN = 1'b1;
  endtask

  // Clear mid-qualification at edge 10, then full requalification from release.
  task automatic test_clr_midway();
    logic [3:0] got, exp;
    D = 1'b0; EN = 1'b1;
    for (int k = 1; k <= 22; k++) tick();
    n_checks++;
    if (Q !== 1'b0) begin
      n_errors++;
      $display("FAIL clr_prep Q got=%b exp=0", Q);
    end
    D = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      CLR = (k == 10);
      tick();
      got = {Q, RISE, FALL, BUSY};
      exp = {1'b0, 1'b0, 1'b0, (k >= 3 && k <= 9)};
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL clr_mid edge=%0d {Q,RISE,FALL,BUSY} got=%b exp=%b", k, got, exp);
      end
    end
    CLR = 1'b0;
    for (int j = 1; j <= 22; j++) begin
      tick();
      got = {Q, RISE, FALL, BUSY};
      exp = {(j >= 19), (j == 19), 1'b0, (j >= 3 && j <= 18)};
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL clr_requal edge=%0d {Q,RISE,FALL,BUSY} got=%b exp=%b", j, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_rise();
    test_fall();
    test_en_alternate();
    test_clr_midway();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
